// File: rtl/multi_port_framing_ctrl.sv
// Multi-port packet framing controller: one independent framing FSM per
// ingress port, with error detection/coding, saturating per-port error
// counters and packet-boundary-only enable updates.

// Single-port framing engine, replicated once per port by the top level.
module framing_port #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic [LEN_W-1:0] max_len,
  input  logic             cnt_clr,
  input  logic             val,
  input  logic             sop,
  input  logic             eop,
  output logic             enable,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE       = 2'd0;
  localparam logic [1:0] CODE_EOP_NO_SOP = 2'd1;
  localparam logic [1:0] CODE_SOP_IN_PKT = 2'd2;
  localparam logic [1:0] CODE_TOO_LONG   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt, len_inc;
  logic [1:0]       code_nxt;
  logic             s, e;

  assign s = val & sop;
  assign e = val & eop;

  // Beat count saturates so very long packets never wrap back under the limit.
  assign len_inc = (&len) ? len : len + LEN_W'(1);

  // Next-state, next-length and error-code decode.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    code_nxt  = CODE_NONE;
    unique case (state)
      IDLE: begin
        len_nxt = '0;
        if (s && !e) begin
          state_nxt = IN_PKT;
          len_nxt   = LEN_W'(1);
        end else if (!s && e) begin
          state_nxt = ERROR;
          code_nxt  = CODE_EOP_NO_SOP;
        end
      end
      IN_PKT: begin
        if (val) begin
          len_nxt = len_inc;
          if (s) begin
            // A new sop mid-packet outranks the length check.
            state_nxt = ERROR;
            code_nxt  = CODE_SOP_IN_PKT;
            len_nxt   = '0;
          end else if ((max_len != '0) && (len_inc > max_len)) begin
            // Over length even if this beat also carries eop.
            state_nxt = ERROR;
            code_nxt  = CODE_TOO_LONG;
            len_nxt   = '0;
          end else if (e) begin
            state_nxt = IDLE;
            len_nxt   = '0;
          end
        end
      end
      ERROR: begin
        // Whatever arrives during the error cycle is dropped.
        state_nxt = IDLE;
        len_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        len_nxt   = '0;
      end
    endcase
  end

  // FSM state, beat length and registered error code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      err_code <= CODE_NONE;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      err_code <= code_nxt;
    end
  end

  assign error = (state == ERROR);

  // Enable only picks up new config when the port is (or returns to) idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  enable <= 1'b0;
    else if (state_nxt == IDLE) enable <= cfg_enable;
  end

  // Saturating error counter; a clear coincident with a new error keeps it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if (cnt_clr)
      err_cnt <= (state_nxt == ERROR) ? CNT_W'(1) : '0;
    else if ((state_nxt == ERROR) && (err_cnt != CNT_MAX))
      err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// Top level: array of per-port engines sharing only cfg_max_len.
module multi_port_framing_ctrl #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       cfg_port_enable,
  input  logic [LEN_W-1:0]           cfg_max_len,
  input  logic [NUM_PORTS-1:0]       cnt_clr,
  input  logic [NUM_PORTS-1:0]       val,
  input  logic [NUM_PORTS-1:0]       sop,
  input  logic [NUM_PORTS-1:0]       eop,
  output logic [NUM_PORTS-1:0]       enable,
  output logic [NUM_PORTS-1:0]       error,
  output logic [2*NUM_PORTS-1:0]     err_code,
  output logic [CNT_W*NUM_PORTS-1:0] err_cnt
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    framing_port #(
      .LEN_W (LEN_W),
      .CNT_W (CNT_W)
    ) u_port (
      .clk        (clk),
      .reset      (reset),
      .cfg_enable (cfg_port_enable[p]),
      .max_len    (cfg_max_len),
      .cnt_clr    (cnt_clr[p]),
      .val        (val[p]),
      .sop        (sop[p]),
      .eop        (eop[p]),
      .enable     (enable[p]),
      .error      (error[p]),
      .err_code   (err_code[2*p +: 2]),
      .err_cnt    (err_cnt[CNT_W*p +: CNT_W])
    );
  end

endmodule

// File: doc/multi_port_framing_ctrl.md
# multi_port_framing_ctrl

Parametrised, multi-port packet framing controller, the successor of the single-port control FSM. It runs one independent framing FSM per ingress port on `val`/`sop`/`eop`, and detects three error classes: EOP without SOP, SOP inside a packet, and packet longer than a programmable maximum. It reports each error with a code and a saturating per-port error counter, and applies per-port enable changes only at packet boundaries. It sits between the port configuration registers and the ingress datapath, whose per-port gating it drives.

## Interface
- `NUM_PORTS`, 4: number of independent ports (≥1).
- `LEN_W`, 16: width of the beat-length counter and of `cfg_max_len`.
- `CNT_W`, 8: width of each per-port error counter.
- `clk`  in  1  clock; all logic rising-edge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `cfg_port_enable`  in  NUM_PORTS  requested enable per port.
- `cfg_max_len`  in  LEN_W  max beats per packet, shared by all ports; 0 = no limit.
- `cnt_clr`  in  NUM_PORTS  per-port error-counter clear pulse.
- `val`  in  NUM_PORTS  beat valid per port.
- `sop`  in  NUM_PORTS  start of packet, qualified by `val`.
- `eop`  in  NUM_PORTS  end of packet, qualified by `val`.
- `enable`  out  NUM_PORTS  registered effective port enable.
- `error`  out  NUM_PORTS  registered one-cycle error pulse.
- `err_code`  out  2*NUM_PORTS  port p at [2p+1:2p]: 0 none, 1 EOP_NO_SOP, 2 SOP_IN_PKT, 3 TOO_LONG.
- `err_cnt`  out  CNT_W*NUM_PORTS  port p at [CNT_W*(p+1)-1:CNT_W*p]; saturating error count.

## Operation
- Ports are fully independent and share no state except `cfg_max_len`.
- Per port: `s = val & sop` and `e = val & eop`. Beats with `val = 0` are ignored in every state.
- The FSM has three states: IDLE, IN_PKT, ERROR. Reset state is IDLE.
- IDLE:
  - `s & e`: single-beat packet, stay IDLE. No length error, even when `cfg_max_len == 1`.
  - `s & !e`: go to IN_PKT, `len = 1`.
  - `!s & e`: go to ERROR, code 1.
  - `val` with neither flag: ignored, stay IDLE.
- IN_PKT, on every valid beat, `len_next = len + 1`, saturating at all-ones.
  - `s` (with or without `e`): go to ERROR, code 2. This has priority over the length check.
  - Else, if `cfg_max_len != 0` and `len_next > cfg_max_len`: go to ERROR, code 3. A beat that carries `e` still errors if it is over length.
  - Else `e`: go to IDLE.
  - Else stay in IN_PKT.
- ERROR: unconditionally go to IDLE next cycle. Any beat present during the ERROR cycle is discarded, including a `sop`.
- `error[p] = (state == ERROR)`. `err_code[p]` holds the code while in ERROR and is 0 otherwise.
- Enable:
  - `enable[p]` loads `cfg_port_enable[p]` on each cycle where the next state is IDLE.
  - Otherwise it holds, so enable never toggles mid-packet or through the ERROR cycle.
- Error counter:
  - `err_cnt[p]` increments by 1 on each transition into ERROR and saturates at `2^CNT_W-1`.
  - `cnt_clr[p]` alone sets it to 0.
  - `cnt_clr[p]` in the same cycle as an ERROR entry sets it to 1, so the new error is not lost.
- `cfg_max_len` is sampled every beat. A change mid-packet takes effect on the next beat.

## Timing
- Reset values: `enable = 0`, `error = 0`, `err_code = 0`, `err_cnt = 0`, all FSMs IDLE, `len = 0`.
- Reset asserted mid-packet returns the port to IDLE immediately. No error is flagged and the counter is cleared.
- All outputs are registered, with 1-cycle latency:
  - an offending beat at cycle N gives `error` high at N+1, for exactly one cycle;
  - `err_cnt` updates at N+1.
- An `eop` at cycle N closing a good packet gives `enable` reflecting `cfg_port_enable` at N+1.
- Back-to-back packets are legal with no idle gap: `eop` at N, `sop` at N+1.
- After an error at N+1, the earliest accepted `sop` is at N+2.
- While in IDLE with no traffic, `enable` follows `cfg_port_enable` with 1-cycle delay.

## Test plan
- Reset, then `cfg_port_enable = 4'b1111` with no traffic -> `enable = 4'b1111` two cycles after reset release. `error = 0` and `err_cnt = 0` on all ports.
- Port 0 receives `sop`, 3 data beats, then `eop` with `cfg_max_len = 5`; `cfg_port_enable[0]` is dropped mid-packet -> no error, and `enable[0]` falls only the cycle after `eop`.
- Port 1 receives `eop` while IDLE -> `error[1]` is high for one cycle with code 1 and `err_cnt[1] = 1`. Port 1 receives `sop` twice without `eop` -> code 2 and `err_cnt[1] = 2`.
- Port 2 with `cfg_max_len = 4` receives a 5-beat packet -> code 3 one cycle after the 5th beat. A 4-beat packet gives no error; a single-beat `sop&eop` packet with `cfg_max_len = 1` gives no error.
- `CNT_W = 2`: 5 errors on port 3 -> `err_cnt[3]` saturates at 3. `cnt_clr[3]` coincident with a 6th error -> `err_cnt[3] = 1`.
- Simultaneous errors on all ports in the same cycle -> every port flags independently with the correct code, and there is no cross-port interference.
